exec_sequencer: RTL and testbench

//   Run/step/halt sequencer gating the mini SRC Control unit. Converts sanitized

---
 rtl/exec_sequencer_if.sv | 36 +++
 rtl/exec_sequencer.sv | 151 +++++++++++++++
 tb/tb_exec_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: groups the request, Control-handshake, breakpoint and
// status signals of the run/step/halt sequencer into one bundle.
// The master side drives requests and Control feedback and receives status.
// The slave side is the sequencer itself.
interface exec_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int PC_W  = 9
);
  logic             run_req;
  logic             step_req;
  logic             halt_req;
  logic             instr_done;
  logic             halt_instr;
  logic [PC_W-1:0]  pc;
  logic [PC_W-1:0]  bp_addr;
  logic             bp_valid;
  logic             cpu_en;
  logic             running;
  logic             halted;
  logic             fault;
  logic             bp_hit;
  logic [1:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run_req, step_req, halt_req, instr_done, halt_instr,
           pc, bp_addr, bp_valid,
    input  cpu_en, running, halted, fault, bp_hit, state, instr_count
  );

  modport slave (
    input  run_req, step_req, halt_req, instr_done, halt_instr,
           pc, bp_addr, bp_valid,
    output cpu_en, running, halted, fault, bp_hit, state, instr_count
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: turns sanitized run/step/halt button pulses into the
// registered clock-enable for Control, counts retired instructions and
// forces HALTED on a halt opcode or on an instruction that never finishes.
// Define EXEC_BP_EN to compile in the PC breakpoint comparator; without it
// pc/bp_addr/bp_valid are ignored and bp_hit stays 0.
module exec_sequencer #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int PC_W    = 9
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  exec_sequencer_if.slave bus
);

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             pause_q, pause_d;
  logic             fault_q, fault_d;
  logic             bp_hit_q, bp_hit_d;
  logic             cpu_en_q;
  logic             halted_q;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_en;
  logic             halt_en;
  logic             timeout_hit;
  logic             bp_match;

`ifdef EXEC_BP_EN
  logic [PC_W-1:0] pc_diff;
  assign pc_diff  = bus.pc ^ bus.bp_addr;
  assign bp_match = bus.bp_valid && (pc_diff == '0);
`else
  logic [PC_W:0] unused_bp;
  assign unused_bp = {bus.bp_valid, bus.pc ^ bus.bp_addr};
  assign bp_match  = 1'b0;
`endif

  // Control feedback only means something while Control is enabled.
  assign done_en     = cpu_en_q && bus.instr_done;
  assign halt_en     = cpu_en_q && bus.halt_instr;
  assign timeout_hit = cpu_en_q && !bus.instr_done && (timer_q == TMR_LAST);

  // Next-state, pause/fault/breakpoint flags, stall timer and retire counter.
  always_comb begin
    state_d  = state_q;
    pause_d  = pause_q;
    fault_d  = fault_q;
    bp_hit_d = bp_hit_q;
    timer_d  = '0;
    count_d  = count_q;

    if (cpu_en_q && !bus.instr_done) begin
      timer_d = timer_q + TMR_W'(1);
    end

    if (done_en && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.run_req) begin
          state_d  = RUN;
          bp_hit_d = 1'b0;
        end else if (bus.step_req) begin
          state_d  = STEP;
          bp_hit_d = 1'b0;
        end
      end
      RUN: begin
        if (halt_en) begin
          state_d = HALTED;
          pause_d = 1'b0;
        end else if (timeout_hit) begin
          state_d = HALTED;
          fault_d = 1'b1;
          pause_d = 1'b0;
        end else if (done_en && (pause_q || bp_match)) begin
          state_d = IDLE;
          pause_d = 1'b0;
          if (bp_match) begin
            bp_hit_d = 1'b1;
          end
        end else if (bus.halt_req || bus.step_req) begin
          pause_d = 1'b1;
        end
      end
      STEP: begin
        if (halt_en) begin
          state_d = HALTED;
        end else if (timeout_hit) begin
          state_d = HALTED;
          fault_d = 1'b1;
        end else if (done_en) begin
          state_d = IDLE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and status registers; outputs are decoded from next state so they
  // line up with the state register on the same edge.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      pause_q  <= 1'b0;
      fault_q  <= 1'b0;
      bp_hit_q <= 1'b0;
      cpu_en_q <= 1'b0;
      halted_q <= 1'b0;
      timer_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pause_q  <= pause_d;
      fault_q  <= fault_d;
      bp_hit_q <= bp_hit_d;
      cpu_en_q <= (state_d == RUN) || (state_d == STEP);
      halted_q <= (state_d == HALTED);
      timer_q  <= timer_d;
      count_q  <= count_d;
    end
  end

  assign bus.cpu_en      = cpu_en_q;
  assign bus.running     = cpu_en_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.bp_hit      = bp_hit_q;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: scoreboard bench for exec_sequencer. Each driven cycle
// runs a behavioural model of the sequencer rules and queues the expected
// post-edge outputs; an independent monitor pops and compares every cycle.
module tb_exec_sequencer;

  localparam int             CNT_W    = 4;
  localparam int             TIMEOUT  = 64;
  localparam int             PC_W     = 9;
  localparam int             CNT_MAX  = (1 << CNT_W) - 1;
  localparam int             M_IDLE   = 0;
  localparam int             M_RUN    = 1;
  localparam int             M_STEP   = 2;
  localparam int             M_HALTED = 3;
  localparam logic [PC_W-1:0] BP_ADDR = 9'h010;

  typedef struct packed {
    logic [1:0]       state;
    logic             cpu_en;
    logic             running;
    logic             halted;
    logic             fault;
    logic             bp_hit;
    logic [CNT_W-1:0] count;
  } exp_t;

  logic CLOCK_50 = 1'b0;
  logic reset;

  exp_t  exp_q[$];
  string tag_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  int m_mode;
  bit m_pend;
  bit m_fault;
  bit m_bp;
  int m_stall;
  int m_count;

  exec_sequencer_if #(.CNT_W(CNT_W), .PC_W(PC_W)) bus();

  exec_sequencer #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT),
    .PC_W   (PC_W)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Drive one cycle of inputs, advance the reference model, queue expectation.
  task automatic applyStimulus(input bit rst, input bit run, input bit step,
                               input bit halt, input bit done, input bit hins,
                               input logic [PC_W-1:0] pcv, input bit bpv,
                               input string tag);
    bit   en;
    bit   retire;
    bit   stop;
    bit   bphit;
    bit   en_new;
    exp_t e;
    @(negedge CLOCK_50);
    reset          = rst;
    bus.run_req    = run;
    bus.step_req   = step;
    bus.halt_req   = halt;
    bus.instr_done = done;
    bus.halt_instr = hins;
    bus.pc         = pcv;
    bus.bp_valid   = bpv;

    if (rst) begin
      m_mode  = M_IDLE;
      m_pend  = 0;
      m_fault = 0;
      m_bp    = 0;
      m_stall = 0;
      m_count = 0;
    end else begin
      en     = (m_mode == M_RUN) || (m_mode == M_STEP);
      retire = en && done;
      stop   = en && hins;
      bphit  = 0;
`ifdef EXEC_BP_EN
      bphit = bpv && (pcv == BP_ADDR);
`endif
      if (retire && m_count < CNT_MAX) m_count++;
      if (m_mode == M_IDLE) begin
        if (run) begin
          m_mode = M_RUN;
          m_bp   = 0;
        end else if (step) begin
          m_mode = M_STEP;
          m_bp   = 0;
        end
      end else if (en) begin
        if (stop) begin
          m_mode = M_HALTED;
          m_pend = 0;
        end else if (!retire && (m_stall + 1 >= TIMEOUT)) begin
          m_mode  = M_HALTED;
          m_fault = 1;
          m_pend  = 0;
        end else if (retire && m_mode == M_STEP) begin
          m_mode = M_IDLE;
        end else if (retire && (m_pend || bphit)) begin
          m_mode = M_IDLE;
          m_pend = 0;
          if (bphit) m_bp = 1;
        end else if (m_mode == M_RUN && (halt || step)) begin
          m_pend = 1;
        end
        m_stall = retire ? 0 : m_stall + 1;
      end
      if (!(m_mode == M_RUN || m_mode == M_STEP)) m_stall = 0;
    end

    en_new    = (m_mode == M_RUN) || (m_mode == M_STEP);
    e.state   = m_mode[1:0];
    e.cpu_en  = en_new;
    e.running = en_new;
    e.halted  = (m_mode == M_HALTED);
    e.fault   = m_fault;
    e.bp_hit  = m_bp;
    e.count   = m_count[CNT_W-1:0];
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic nop(input string tag, input int n = 1);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, '0, 0, tag);
  endtask

  // Compare one DUT output snapshot against the queued expectation.
  task automatic checkOutput(input exp_t e, input string tag);
    exp_t a;
    a.state   = bus.state;
    a.cpu_en  = bus.cpu_en;
    a.running = bus.running;
    a.halted  = bus.halted;
    a.fault   = bus.fault;
    a.bp_hit  = bus.bp_hit;
    a.count   = bus.instr_count;
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("[TB] FAIL %s @%0t: got st=%b en=%b run=%b hlt=%b flt=%b bp=%b cnt=%0d, expected st=%b en=%b run=%b hlt=%b flt=%b bp=%b cnt=%0d",
               tag, $time, a.state, a.cpu_en, a.running, a.halted, a.fault, a.bp_hit, a.count,
               e.state, e.cpu_en, e.running, e.halted, e.fault, e.bp_hit, e.count);
    end
  endtask

  // Monitor: one output snapshot per clock, checked just after the edge.
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checkOutput(e, t);
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int ph;
    bit rr, ss, hh, dd, hi, bv;
    logic [PC_W-1:0] pv;

    reset          = 1'b1;
    bus.run_req    = 1'b0;
    bus.step_req   = 1'b0;
    bus.halt_req   = 1'b0;
    bus.instr_done = 1'b0;
    bus.halt_instr = 1'b0;
    bus.pc         = '0;
    bus.bp_addr    = BP_ADDR;
    bus.bp_valid   = 1'b0;

    $display("[TB] start");

    applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, "reset");
    applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, "reset");
    applyStimulus(0, 0, 0, 1, 1, 1, '0, 0, "idle_ignore");
    applyStimulus(0, 1, 0, 0, 0, 0, '0, 0, "t1_run");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, '0, 0, "t1_done");
      nop("t1_gap", 2);
    end

    applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, "t2_reset");
    applyStimulus(0, 1, 1, 0, 0, 0, '0, 0, "t2_run_wins");
    applyStimulus(0, 0, 0, 1, 1, 0, '0, 0, "t2_done_run");
    applyStimulus(0, 0, 0, 0, 1, 0, '0, 0, "t2_pause");
    applyStimulus(0, 0, 1, 0, 0, 0, '0, 0, "t2_step");
    nop("t2_wait", 2);
    applyStimulus(0, 0, 1, 0, 0, 0, '0, 0, "t2_step_ignored");
    nop("t2_wait", 1);
    applyStimulus(0, 0, 0, 0, 1, 0, '0, 0, "t2_step_done");
    nop("t2_after", 2);

    applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, "t3_reset");
    applyStimulus(0, 1, 0, 0, 0, 0, '0, 0, "t3_run");
    applyStimulus(0, 0, 0, 1, 0, 0, '0, 0, "t3_halt_req");
    nop("t3_wait", 3);
    applyStimulus(0, 0, 0, 0, 1, 0, '0, 0, "t3_pause_done");
    nop("t3_idle", 1);
    applyStimulus(0, 1, 0, 0, 0, 0, '0, 0, "t3_rerun");
    applyStimulus(0, 0, 0, 0, 1, 1, '0, 0, "t3_halt_instr");
    applyStimulus(0, 1, 1, 0, 1, 0, '0, 0, "t3_halted_ignore");
    nop("t3_halted", 2);

    applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, "t4_reset");
    applyStimulus(0, 1, 0, 0, 0, 0, '0, 0, "t4_run");
    nop("t4_stall", TIMEOUT + 2);
    applyStimulus(0, 1, 0, 0, 0, 0, '0, 0, "t4_run_ignored");
    applyStimulus(0, 0, 1, 0, 0, 0, '0, 0, "t4_step_ignored");
    applyStimulus(1, 0, 0, 0, 0, 0, '0, 0, "t4_reset_clears");
    nop("t4_idle", 1);

    applyStimulus(0, 1, 0, 0, 0, 0, '0, 0, "t5_run");
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 0, 1, 0, '0, 0, "t5_saturate");
    applyStimulus(1, 0, 0, 0, 1, 0, '0, 0, "t5_reset_mid_run");
    nop("t5_idle", 1);

    applyStimulus(0, 1, 0, 0, 0, 0, '0, 1, "t6_run");
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h011, 1, "t6_miss");
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h010, 0, "t6_unarmed");
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h010, 1, "t6_hit");
    nop("t6_idle", 1);
    applyStimulus(0, 1, 0, 0, 0, 0, '0, 1, "t6_run_clears");
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h010, 1, "t6_hit_again");
    applyStimulus(0, 0, 1, 0, 0, 0, '0, 1, "t6_step");
    applyStimulus(0, 0, 0, 0, 1, 0, 9'h010, 1, "t6_step_unaffected");

    for (int i = 0; i < 3000; i++) begin
      ph = (i / 400) % 4;
      rr = ($urandom_range(0, 11) == 0);
      ss = ($urandom_range(0, 11) == 0);
      hh = ($urandom_range(0, 11) == 0);
      case (ph)
        0:       dd = ($urandom_range(0, 3) == 0);
        1:       dd = ($urandom_range(0, 1) == 0);
        2:       dd = ($urandom_range(0, 99) == 0);
        default: dd = ($urandom_range(0, 7) == 0);
      endcase
      hi = ($urandom_range(0, 79) == 0);
      bv = ($urandom_range(0, 1) == 0);
      pv = 9'h00E + PC_W'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 149) == 0), rr, ss, hh, dd, hi, pv, bv, "random");
    end

    nop("drain", 1);
    repeat (3) @(posedge CLOCK_50);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
